// File: rtl/wb_pipe_master_if.sv
// Request/response handshake plus pipelined Wishbone initiator signals for wb_pipe_master.
// The master modport is the bridge's view; the slave modport is the client/responder view.
interface wb_pipe_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_sel_i;

    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
        input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sel_i,
        output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_pipe_master.sv
// Pipelined Wishbone initiator: one request per cycle, in-order one-cycle response pulses.
// Optional watchdog/ABORT state compiled in with WB_PIPE_MASTER_TIMEOUT_EN.
module wb_pipe_master #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    wb_pipe_master_if.master bus
);
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_max
        $error("MAX_OUTSTANDING out of range 1..7");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
        ABORT  = 2'd2,
`endif
        ACTIVE = 2'd1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, cnt_pop, inflight;
    logic [7:0]  weq_q, weq_d, weq_pop;
    logic        stb_q, stb_d, we_q, we_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rdy_en_q;
    logic        issue, rsp_evt, ready, accept, timeout;
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
    logic [7:0]  wdog_q, wdog_d;
    logic        wd_clr;
`endif

    always_comb begin
        issue    = stb_q & ~bus.wb_stall_i;
        rsp_evt  = (state_q == ACTIVE) && (bus.wb_ack_i || bus.wb_err_i) && (cnt_q != 4'd0);
        inflight = cnt_q + {3'b000, stb_q} - {3'b000, issue};
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
        wd_clr   = issue | bus.wb_ack_i | bus.wb_err_i;
        timeout  = (state_q == ACTIVE) && (cnt_q != 4'd0) && !wd_clr
                   && (wdog_q == 8'(TIMEOUT_CYCLES - 1));
        wdog_d   = wdog_q;
        if (state_q != ACTIVE || wd_clr || timeout) wdog_d = 8'd0;
        else if (cnt_q != 4'd0)                    wdog_d = wdog_q + 8'd1;
`else
        timeout  = 1'b0;
`endif
        // rdy_en_q keeps ready low through reset and releases on the first edge after it
        ready    = rdy_en_q && (state_q == IDLE || state_q == ACTIVE) && !timeout
                   && (!stb_q || !bus.wb_stall_i) && (inflight < 4'(MAX_OUTSTANDING));
        accept   = bus.req_valid_i & ready;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        weq_d     = weq_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_vld_d = 1'b0;
        rsp_dat_d = '0;
        rsp_err_d = 1'b0;
        weq_pop   = rsp_evt ? (weq_q >> 1) : weq_q;
        cnt_pop   = cnt_q - {3'b000, rsp_evt};

        if (accept) begin
            stb_d = 1'b1;
            we_d  = bus.req_we_i;
            adr_d = bus.req_addr_i;
            dat_d = bus.req_wdata_i;
            sel_d = bus.req_sel_i;
        end else if (issue) begin
            stb_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            dat_d = '0;
            sel_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (rsp_evt) begin
                    rsp_vld_d = 1'b1;
                    rsp_err_d = bus.wb_err_i;
                    rsp_dat_d = weq_q[0] ? 32'd0 : bus.wb_dat_i;
                end
                // weq holds the we bit of each issued transfer, oldest in bit 0
                cnt_d = cnt_pop + {3'b000, issue};
                weq_d = issue ? (weq_pop | ({7'b0, we_q} << cnt_pop)) : weq_pop;
                if (!stb_d && cnt_d == 4'd0) state_d = IDLE;
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
                if (timeout) begin
                    state_d = ABORT;
                    cnt_d   = cnt_q + {3'b000, stb_q};
                    weq_d   = '0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                    sel_d   = '0;
                end
`endif
            end
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
            ABORT: begin
                if (cnt_q != 4'd0) begin
                    rsp_vld_d = 1'b1;
                    rsp_err_d = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            weq_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rdy_en_q  <= 1'b0;
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
            wdog_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            weq_q     <= weq_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rdy_en_q  <= 1'b1;
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_vld_q;
    assign bus.rsp_rdata_o = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.wb_cyc_o    = (state_q == ACTIVE);
    assign bus.wb_stb_o    = stb_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_sel_o    = sel_q;
endmodule

// File: tb/tb_wb_pipe_master.sv
// Directed bench for wb_pipe_master (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8).
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_wb_pipe_master;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    wb_pipe_master_if bus();

    wb_pipe_master #(.MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        bus.req_valid_i = v;
        bus.req_we_i    = we;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        bus.req_sel_i   = s;
    endtask

    task automatic wb_drive(input logic stall, input logic ack, input logic err,
                            input logic [31:0] d);
        bus.wb_stall_i = stall;
        bus.wb_ack_i   = ack;
        bus.wb_err_i   = err;
        bus.wb_dat_i   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got 0x00000000 expected 0x00000001");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   acc, iss, rsps, outst, n;
        logic ack_nxt, issue_now;

        rst_n = 1'b1;
        drive_req(0, 0, 0, 0, 0);
        wb_drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cyc",   {31'd0, bus.wb_cyc_o},    0);
        chk("rst_stb",   {31'd0, bus.wb_stb_o},    0);
        chk("rst_we",    {31'd0, bus.wb_we_o},     0);
        chk("rst_adr",   bus.wb_adr_o,             0);
        chk("rst_dat",   bus.wb_dat_o,             0);
        chk("rst_sel",   {28'd0, bus.wb_sel_o},    0);
        chk("rst_ready", {31'd0, bus.req_ready_o}, 0);
        chk("rst_rsp",   {31'd0, bus.rsp_valid_o}, 0);
        chk("rst_rdata", bus.rsp_rdata_o,          0);
        chk("rst_err",   {31'd0, bus.rsp_err_o},   0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        #1;
        chk("rel_ready", {31'd0, bus.req_ready_o}, 1);

        // single read, ack one cycle after issue
        drive_req(1, 0, 32'h1000_0004, 0, 4'hF);
        #1;
        chk("rd_ready", {31'd0, bus.req_ready_o}, 1);
        tick;
        drive_req(0, 0, 0, 0, 0);
        #1;
        chk("rd_stb", {31'd0, bus.wb_stb_o}, 1);
        chk("rd_cyc", {31'd0, bus.wb_cyc_o}, 1);
        chk("rd_adr", bus.wb_adr_o, 32'h1000_0004);
        chk("rd_we",  {31'd0, bus.wb_we_o}, 0);
        chk("rd_sel", {28'd0, bus.wb_sel_o}, 32'hF);
        tick;
        wb_drive(0, 1, 0, 32'hDEAD_BEEF);
        #1;
        chk("rd_stb_off",  {31'd0, bus.wb_stb_o},    0);
        chk("rd_cyc_hold", {31'd0, bus.wb_cyc_o},    1);
        chk("rd_no_rsp",   {31'd0, bus.rsp_valid_o}, 0);
        tick;
        wb_drive(0, 0, 0, 0);
        #1;
        chk("rd_rsp",   {31'd0, bus.rsp_valid_o}, 1);
        chk("rd_rdata", bus.rsp_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err",   {31'd0, bus.rsp_err_o}, 0);
        chk("rd_cyc_drop", {31'd0, bus.wb_cyc_o}, 0);
        tick;
        #1;
        chk("rd_pulse_end", {31'd0, bus.rsp_valid_o}, 0);

        // four back-to-back writes; responder acks each one cycle after its issue
        acc = 0; iss = 0; rsps = 0; outst = 0; ack_nxt = 1'b0;
        for (int c = 0; c < 24 && rsps < 4; c++) begin
            drive_req(acc < 4, 1, 32'h100 + 32'(4 * acc), 32'hC0DE_0000 + 32'(acc), 4'hF);
            wb_drive(0, ack_nxt, 0, 32'hBAD0_BAD0);
            #1;
            if (bus.rsp_valid_o) begin
                chk("w4_rdata", bus.rsp_rdata_o, 0);
                chk("w4_err", {31'd0, bus.rsp_err_o}, 0);
                rsps++;
            end
            if (acc > 0 && rsps < 4) chk("w4_cyc", {31'd0, bus.wb_cyc_o}, 1);
            issue_now = bus.wb_stb_o & ~bus.wb_stall_i;
            if (issue_now) begin
                chk("w4_adr", bus.wb_adr_o, 32'h100 + 32'(4 * iss));
                chk("w4_dat", bus.wb_dat_o, 32'hC0DE_0000 + 32'(iss));
                iss++;
            end
            outst = outst + (issue_now ? 1 : 0) - ((ack_nxt && outst > 0) ? 1 : 0);
            chk("w4_outst_le2", {31'd0, outst <= 2}, 1);
            if (bus.req_valid_i && bus.req_ready_o) acc++;
            ack_nxt = issue_now;
            tick;
        end
        chk("w4_rsp_count", 32'(rsps), 4);
        chk("w4_issue_count", 32'(iss), 4);
        drive_req(0, 0, 0, 0, 0);
        wb_drive(0, 0, 0, 0);
        #1;

        // stalled first issue on a misaligned write
        drive_req(1, 1, 32'h0000_0203, 32'hA5A5_0001, 4'h3);
        tick;
        wb_drive(1, 0, 0, 0);
        drive_req(1, 0, 32'h0000_0500, 0, 4'hF);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("st_stb",   {31'd0, bus.wb_stb_o}, 1);
            chk("st_adr",   bus.wb_adr_o, 32'h0000_0203);
            chk("st_dat",   bus.wb_dat_o, 32'hA5A5_0001);
            chk("st_sel",   {28'd0, bus.wb_sel_o}, 32'h3);
            chk("st_ready", {31'd0, bus.req_ready_o}, 0);
            tick;
            #1;
        end
        wb_drive(0, 0, 0, 0);
        drive_req(0, 0, 0, 0, 0);
        #1;
        chk("st_stb_last", {31'd0, bus.wb_stb_o}, 1);
        tick;
        wb_drive(0, 1, 0, 32'hFFFF_FFFF);
        #1;
        chk("st_issued_once", {31'd0, bus.wb_stb_o}, 0);
        chk("st_we_zero", {31'd0, bus.wb_we_o}, 0);
        tick;
        wb_drive(0, 0, 0, 0);
        #1;
        chk("st_rsp",   {31'd0, bus.rsp_valid_o}, 1);
        chk("st_wr_rdata_zero", bus.rsp_rdata_o, 0);
        chk("st_cyc_drop", {31'd0, bus.wb_cyc_o}, 0);
        tick;
        #1;
        chk("st_one_rsp", {31'd0, bus.rsp_valid_o}, 0);

        // two reads, second completes with ack+err; pipeline full holds ready low
        drive_req(1, 0, 32'h300, 0, 4'hF);
        #1;
        tick;
        drive_req(1, 0, 32'h304, 0, 4'hF);
        #1;
        chk("e2_ready_second", {31'd0, bus.req_ready_o}, 1);
        tick;
        drive_req(0, 0, 0, 0, 0);
        #1;
        chk("e2_adr2", bus.wb_adr_o, 32'h304);
        tick;
        drive_req(1, 0, 32'h308, 0, 4'hF);
        #1;
        chk("e2_full_ready", {31'd0, bus.req_ready_o}, 0);
        chk("e2_cyc", {31'd0, bus.wb_cyc_o}, 1);
        drive_req(0, 0, 0, 0, 0);
        wb_drive(0, 1, 0, 32'h1111_1111);
        tick;
        wb_drive(0, 1, 1, 32'h2222_2222);
        #1;
        chk("e2_rsp1",   {31'd0, bus.rsp_valid_o}, 1);
        chk("e2_rdata1", bus.rsp_rdata_o, 32'h1111_1111);
        chk("e2_err1",   {31'd0, bus.rsp_err_o}, 0);
        tick;
        wb_drive(0, 1, 0, 32'h3333_3333);
        #1;
        chk("e2_rsp2",   {31'd0, bus.rsp_valid_o}, 1);
        chk("e2_rdata2", bus.rsp_rdata_o, 32'h2222_2222);
        chk("e2_err2",   {31'd0, bus.rsp_err_o}, 1);
        chk("e2_cyc_drop", {31'd0, bus.wb_cyc_o}, 0);
        tick;
        wb_drive(0, 0, 0, 0);
        #1;
        chk("e2_stray_ack", {31'd0, bus.rsp_valid_o}, 0);
        tick;
        #1;
        chk("e2_quiet",  {31'd0, bus.rsp_valid_o}, 0);
        chk("e2_ready_idle", {31'd0, bus.req_ready_o}, 1);

        // reset with two transfers outstanding
        drive_req(1, 0, 32'h400, 0, 4'hF);
        #1;
        tick;
        drive_req(1, 0, 32'h404, 0, 4'hF);
        #1;
        tick;
        drive_req(0, 0, 0, 0, 0);
        #1;
        tick;
        #1;
        chk("rm_cyc_pre", {31'd0, bus.wb_cyc_o}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rm_cyc",   {31'd0, bus.wb_cyc_o},    0);
        chk("rm_stb",   {31'd0, bus.wb_stb_o},    0);
        chk("rm_adr",   bus.wb_adr_o,             0);
        chk("rm_ready", {31'd0, bus.req_ready_o}, 0);
        chk("rm_rsp",   {31'd0, bus.rsp_valid_o}, 0);
        wb_drive(0, 1, 0, 32'h5555_5555);
        tick;
        rst_n = 1'b1;
        tick;
        #1;
        chk("rm_ready_rel", {31'd0, bus.req_ready_o}, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid_o) n++;
            tick;
            #1;
        end
        chk("rm_no_rsp", 32'(n), 0);
        wb_drive(0, 0, 0, 0);

`ifdef WB_PIPE_MASTER_TIMEOUT_EN
        // two reads never acknowledged
        drive_req(1, 0, 32'h600, 0, 4'hF);
        #1;
        tick;
        drive_req(1, 0, 32'h604, 0, 4'hF);
        #1;
        tick;
        drive_req(0, 0, 0, 0, 0);
        #1;
        tick;
        #1;
        n = 0;
        while (bus.wb_cyc_o === 1'b1 && n < 40) begin
            tick;
            #1;
            n++;
        end
        chk("to_cycles", 32'(n), 8);
        chk("to_no_rsp_yet", {31'd0, bus.rsp_valid_o}, 0);
        chk("to_ready_abort", {31'd0, bus.req_ready_o}, 0);
        tick;
        #1;
        chk("to_rsp1", {31'd0, bus.rsp_valid_o}, 1);
        chk("to_err1", {31'd0, bus.rsp_err_o}, 1);
        chk("to_ready_abort2", {31'd0, bus.req_ready_o}, 0);
        tick;
        #1;
        chk("to_rsp2", {31'd0, bus.rsp_valid_o}, 1);
        chk("to_err2", {31'd0, bus.rsp_err_o}, 1);
        chk("to_ready_idle", {31'd0, bus.req_ready_o}, 1);
        tick;
        #1;
        chk("to_done", {31'd0, bus.rsp_valid_o}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
